// File: rtl/multiplier_arbiter_taint_track_word.sv
// multiplier_arbiter_taint_track_word
//   Two requesters share one sequential multiplier. Round-robin arbitration runs
//   in IDLE. The winner's operands are latched and a one-cycle start pulse is sent.
//   The FSM then waits for the multiplier's done signal and returns the product on
//   a valid/ready response channel. Each data/control output carries one taint bit.
// Ports
//   clk, rst                      clock, async active-low reset
//   req{0,1}, a{0,1}, b{0,1} (+_t) requester request/operands with taints
//   gnt0, gnt1, gnt_t             combinational grant pulse in IDLE, grant taint
//   mul_start, mul_multiplier, mul_multiplicand (+_t)  multiplier launch side
//   mul_product, mul_done (+_t)   multiplier result side
//   rsp_valid, rsp_id, rsp_product, rsp_ready (+_t)    response channel
//   busy                          FSM not in IDLE
module multiplier_arbiter_taint_track_word #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req0_t,
  input  logic [WIDTH-1:0]   a0,
  input  logic               a0_t,
  input  logic [WIDTH-1:0]   b0,
  input  logic               b0_t,
  input  logic               req1,
  input  logic               req1_t,
  input  logic [WIDTH-1:0]   a1,
  input  logic               a1_t,
  input  logic [WIDTH-1:0]   b1,
  input  logic               b1_t,
  output logic               gnt0,
  output logic               gnt1,
  output logic               gnt_t,
  output logic               mul_start,
  output logic               mul_start_t,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic               mul_multiplier_t,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic               mul_multiplicand_t,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_product_t,
  input  logic               mul_done,
  input  logic               mul_done_t,
  output logic               rsp_valid,
  output logic               rsp_valid_t,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               rsp_product_t,
  input  logic               rsp_ready,
  input  logic               rsp_ready_t,
  output logic               busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]         state;
  logic               rr_last;   // last winner; 1 means requester 0 has priority next
  logic               owner;
  logic               ctl_t;     // sticky control-path taint
  logic [WIDTH-1:0]   op_a, op_b;
  logic               op_a_t, op_b_t;
  logic [2*WIDTH-1:0] prod;
  logic               prod_t;

  // Requester operands indexed by requester id.
  logic [1:0][WIDTH-1:0] req_a, req_b;
  logic [1:0]            req_a_t, req_b_t;
  assign req_a   = {a1, a0};
  assign req_b   = {b1, b0};
  assign req_a_t = {a1_t, a0_t};
  assign req_b_t = {b1_t, b0_t};

  // Requester 1 wins when alone, or on a tie when requester 0 won last.
  logic win1, grant;
  assign win1  = req1 & (~req0 | ~rr_last);
  // Reset gating keeps the grant outputs low while reset is held.
  assign grant = rst & (state == S_IDLE) & (req0 | req1);

  assign gnt0               = grant & ~win1;
  assign gnt1               = grant & win1;
  assign gnt_t              = ctl_t;
  assign mul_start          = (state == S_LAUNCH);
  assign mul_start_t        = ctl_t;
  assign mul_multiplier     = op_a;
  assign mul_multiplier_t   = op_a_t | ctl_t;
  assign mul_multiplicand   = op_b;
  assign mul_multiplicand_t = op_b_t | ctl_t;
  assign rsp_valid          = (state == S_RESP);
  assign rsp_valid_t        = ctl_t;
  assign rsp_id             = owner;
  assign rsp_product        = prod;
  assign rsp_product_t      = prod_t;
  assign busy               = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rr_last <= 1'b1;
      owner   <= 1'b0;
      ctl_t   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_a_t  <= 1'b0;
      op_b_t  <= 1'b0;
      prod    <= '0;
      prod_t  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            state   <= S_LAUNCH;
            op_a    <= req_a[win1];
            op_b    <= req_b[win1];
            op_a_t  <= req_a_t[win1];
            op_b_t  <= req_b_t[win1];
            owner   <= win1;
            rr_last <= win1;
            ctl_t   <= ctl_t | req0_t | req1_t;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (mul_done) begin
            state  <= S_RESP;
            prod   <= mul_product;
            prod_t <= mul_product_t | ctl_t;
            ctl_t  <= ctl_t | mul_done_t;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
            ctl_t <= ctl_t | rsp_ready_t;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter_taint_track_word.sv
module tb_multiplier_arbiter_taint_track_word;
  localparam int W = 32;

  logic clk, rst;
  logic req0, req0_t, a0_t, b0_t, req1, req1_t, a1_t, b1_t;
  logic [W-1:0] a0, b0, a1, b1;
  logic gnt0, gnt1, gnt_t, mul_start, mul_start_t;
  logic [W-1:0] mul_multiplier, mul_multiplicand;
  logic mul_multiplier_t, mul_multiplicand_t;
  logic [2*W-1:0] mul_product, rsp_product;
  logic mul_product_t, mul_done, mul_done_t;
  logic rsp_valid, rsp_valid_t, rsp_id, rsp_product_t, rsp_ready, rsp_ready_t, busy;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: last winner id and sticky control taint.
  int   last_w;
  logic m_ctl;

  multiplier_arbiter_taint_track_word #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req0_t(req0_t), .a0(a0), .a0_t(a0_t), .b0(b0), .b0_t(b0_t),
    .req1(req1), .req1_t(req1_t), .a1(a1), .a1_t(a1_t), .b1(b1), .b1_t(b1_t),
    .gnt0(gnt0), .gnt1(gnt1), .gnt_t(gnt_t),
    .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier), .mul_multiplier_t(mul_multiplier_t),
    .mul_multiplicand(mul_multiplicand), .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product), .mul_product_t(mul_product_t),
    .mul_done(mul_done), .mul_done_t(mul_done_t),
    .rsp_valid(rsp_valid), .rsp_valid_t(rsp_valid_t), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_product_t(rsp_product_t),
    .rsp_ready(rsp_ready), .rsp_ready_t(rsp_ready_t), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pre);
    chk({pre, "_gnt0"}, gnt0, 0);
    chk({pre, "_gnt1"}, gnt1, 0);
    chk({pre, "_gnt_t"}, gnt_t, 0);
    chk({pre, "_start"}, mul_start, 0);
    chk({pre, "_start_t"}, mul_start_t, 0);
    chk({pre, "_mplier"}, mul_multiplier, 0);
    chk({pre, "_mplier_t"}, mul_multiplier_t, 0);
    chk({pre, "_mcand"}, mul_multiplicand, 0);
    chk({pre, "_mcand_t"}, mul_multiplicand_t, 0);
    chk({pre, "_rsp_valid"}, rsp_valid, 0);
    chk({pre, "_rsp_valid_t"}, rsp_valid_t, 0);
    chk({pre, "_rsp_id"}, rsp_id, 0);
    chk({pre, "_rsp_prod"}, rsp_product, 0);
    chk({pre, "_rsp_prod_t"}, rsp_product_t, 0);
    chk({pre, "_busy"}, busy, 0);
  endtask

  task automatic reset_dut();
    mul_done = 0; mul_done_t = 0; rsp_ready = 0; rsp_ready_t = 0;
    rst = 0;
    #1;
    chk_zero("rst");
    m_ctl  = 0;
    last_w = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  // One full transaction. Entered just after a rising edge with the FSM in IDLE
  // and requests already driven. The multiplier is modelled here as well: it
  // answers lat cycles into WAIT with the product of whatever operands it sees.
  task automatic do_txn(input int lat, input int hold, input logic rdy_t, input logic late_req1);
    int w;
    logic [W-1:0] ea, eb;
    logic ea_t, eb_t, ep_t;
    logic [63:0] ep;
    #1;
    if (req0 && !req1)      w = 0;
    else if (req1 && !req0) w = 1;
    else                    w = (last_w == 0) ? 1 : 0;
    ea   = (w == 1) ? a1 : a0;
    eb   = (w == 1) ? b1 : b0;
    ea_t = (w == 1) ? a1_t : a0_t;
    eb_t = (w == 1) ? b1_t : b0_t;
    ep   = 64'(ea) * 64'(eb);
    chk("gnt0", gnt0, (w == 0));
    chk("gnt1", gnt1, (w == 1));
    chk("gnt_t", gnt_t, m_ctl);
    chk("idle_busy", busy, 0);
    m_ctl  = m_ctl | req0_t | req1_t;
    last_w = w;
    ep_t   = ea_t | eb_t | m_ctl;

    tick();
    chk("launch_start", mul_start, 1);
    chk("launch_start_t", mul_start_t, m_ctl);
    chk("launch_mplier", mul_multiplier, ea);
    chk("launch_mplier_t", mul_multiplier_t, ea_t | m_ctl);
    chk("launch_mcand", mul_multiplicand, eb);
    chk("launch_mcand_t", mul_multiplicand_t, eb_t | m_ctl);
    chk("launch_busy", busy, 1);
    chk("launch_nognt", gnt0 | gnt1, 0);

    tick();
    chk("wait_start", mul_start, 0);
    repeat (lat) begin
      chk("wait_novalid", rsp_valid, 0);
      tick();
    end
    chk("wait_mplier_hold", mul_multiplier, ea);
    mul_done      = 1;
    mul_done_t    = 0;
    mul_product   = 64'(mul_multiplier) * 64'(mul_multiplicand);
    mul_product_t = mul_multiplier_t | mul_multiplicand_t;
    tick();
    mul_done    = 0;
    mul_product = '0;
    if (late_req1) req1 = 1;

    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_valid_t", rsp_valid_t, m_ctl);
    chk("rsp_id", rsp_id, w);
    chk("rsp_product", rsp_product, ep);
    chk("rsp_product_t", rsp_product_t, ep_t);
    repeat (hold) begin
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_product", rsp_product, ep);
      chk("hold_id", rsp_id, w);
      chk("hold_mcand", mul_multiplicand, eb);
      chk("hold_nognt", gnt0 | gnt1, 0);
    end
    rsp_ready   = 1;
    rsp_ready_t = rdy_t;
    #1;
    chk("ready_valid", rsp_valid, 1);
    chk("ready_nognt", gnt0 | gnt1, 0);
    tick();
    rsp_ready   = 0;
    rsp_ready_t = 0;
    m_ctl = m_ctl | rdy_t;
    chk("post_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [1:0] r;
    rst = 0;
    req0 = 0; req0_t = 0; a0 = 0; a0_t = 0; b0 = 0; b0_t = 0;
    req1 = 0; req1_t = 0; a1 = 0; a1_t = 0; b1 = 0; b1_t = 0;
    mul_product = 0; mul_product_t = 0; mul_done = 0; mul_done_t = 0;
    rsp_ready = 0; rsp_ready_t = 0;
    last_w = 1; m_ctl = 0;

    // Reset with a request pending: grant must stay low.
    req0 = 1;
    reset_dut();
    req0 = 0;
    tick();

    // Basic 3*5.
    req0 = 1; a0 = 3; b0 = 5;
    do_txn(2, 0, 0, 0);
    req0 = 0;

    // Full-width product, no truncation.
    req0 = 1; a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
    do_txn(1, 0, 0, 0);
    chk("full_width", rsp_product, 64'hFFFFFFFE00000001);
    req0 = 0;

    // Backpressure for 5 cycles; req1 appears during RESP, granted only after ready.
    req0 = 1; a0 = 7; b0 = 9; a1 = 11; b1 = 13;
    do_txn(0, 5, 0, 1);
    req0 = 0;
    do_txn(1, 0, 0, 0);
    req1 = 0;

    // Tie held across 3 transactions: alternation 0,1,0.
    reset_dut();
    req0 = 1; req1 = 1; a0 = 6; b0 = 7; a1 = 32'h10001; b1 = 32'h20003;
    do_txn(0, 0, 0, 0);
    do_txn(3, 1, 0, 0);
    do_txn(1, 0, 0, 0);
    req0 = 0; req1 = 0;

    // Randomized traffic with random operand taints.
    for (int i = 0; i < 24; i++) begin
      r = 2'($urandom_range(1, 3));
      req0 = r[0]; req1 = r[1];
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      a0_t = 1'($urandom_range(0, 1)); b0_t = 1'($urandom_range(0, 1));
      a1_t = 1'($urandom_range(0, 1)); b1_t = 1'($urandom_range(0, 1));
      do_txn($urandom_range(0, 4), $urandom_range(0, 3), 1'b0, 1'b0);
    end
    req0 = 0; req1 = 0; a0_t = 0; b0_t = 0; a1_t = 0; b1_t = 0;

    // Taint: operand taint only, then a tainted request makes control taint sticky.
    reset_dut();
    req0 = 1; a0 = 21; b0 = 2; a0_t = 1;
    do_txn(1, 0, 0, 0);
    req0 = 0; a0_t = 0;
    req1 = 1; req1_t = 1; a1 = 4; b1 = 4;
    do_txn(0, 0, 0, 0);
    req1 = 0; req1_t = 0;
    req0 = 1; a0 = 2; b0 = 2;
    do_txn(2, 1, 0, 0);
    req0 = 0;
    chk("sticky_gnt_t", gnt_t, 1);
    chk("sticky_rsp_valid_t", rsp_valid_t, 1);
    reset_dut();
    tick();

    // Reset asserted in WAIT, then a stray done after release.
    req0 = 1; a0 = 9; b0 = 9;
    tick();
    req0 = 0;
    tick();
    chk("r6_wait_busy", busy, 1);
    #2;
    rst = 0;
    #1;
    chk_zero("r6");
    @(posedge clk);
    #1;
    rst = 1; m_ctl = 0; last_w = 1;
    mul_done = 1; mul_product = 64'h1234;
    tick();
    mul_done = 0; mul_product = 0;
    chk("r6_late_valid", rsp_valid, 0);
    chk("r6_late_busy", busy, 0);
    chk("r6_late_prod", rsp_product, 0);
    tick();
    chk("r6_late_valid2", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
